// File: rtl/mapped_ram.sv
// Address-mapped, byte-enabled RAM with 1-cycle registered read data and tri-stated output.
// Defining MAPPED_RAM_CLEAR_EN compiles in a post-reset sweep that zeroes every word before ready rises.
module mapped_ram #(
   parameter int unsigned     DATA_W     = 64,
   parameter int unsigned     ADDR_W     = 64,
   parameter int unsigned     DEPTH_LOG2 = 8,
   parameter int unsigned     ID_W       = 8,
   parameter logic [ID_W-1:0] BASE_ID    = 8'b00000010
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   in,
   input  logic                write,
   input  logic                read,
   input  logic [DATA_W/8-1:0] byte_en,
   output logic                ready,
   output logic                out_valid,
   output logic [DATA_W-1:0]   out
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned NB_W  = DATA_W / 8;

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [DATA_W-1:0]     rd_q, rd_d;
   logic                  out_valid_q, out_valid_d;
   logic                  ready_q, ready_d;

   logic                  sel, accept, unused_addr;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] mem_idx;
   logic [DATA_W-1:0]     mem_wdata;
   logic [NB_W-1:0]       mem_be;

`ifdef MAPPED_RAM_CLEAR_EN
   localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  clr_cnt_q, clr_cnt_d;
`endif

   assign sel         = (address[ADDR_W-1 -: ID_W] == BASE_ID);
   assign idx         = address[DEPTH_LOG2-1:0];
   assign unused_addr = ^address[ADDR_W-ID_W-1:DEPTH_LOG2];
   assign accept      = sel & ready_q & (read | write);

   always_comb begin
      out_valid_d = 1'b0;
      rd_d        = rd_q;
      mem_we      = 1'b0;
      mem_idx     = idx;
      mem_wdata   = in;
      mem_be      = byte_en;
      ready_d     = ready_q;
      // Read samples the array before this edge's write lands: read-before-write on a shared index.
      if (accept && read) begin
         out_valid_d = 1'b1;
         rd_d        = mem_q[idx];
      end
      if (accept && write) begin
         mem_we = 1'b1;
      end
`ifdef MAPPED_RAM_CLEAR_EN
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == CLEAR) begin
         mem_we    = 1'b1;
         mem_idx   = clr_cnt_q[DEPTH_LOG2-1:0];
         mem_wdata = '0;
         mem_be    = '1;
         clr_cnt_d = clr_cnt_q + CNT_W'(1);
         // Leave CLEAR on the edge that writes the last word; counter parks at DEPTH.
         if (clr_cnt_d == CNT_W'(DEPTH)) begin
            state_d = RUN;
            ready_d = 1'b1;
         end
      end
`else
      ready_d = 1'b1;
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_q        <= '0;
         out_valid_q <= 1'b0;
         ready_q     <= 1'b0;
`ifdef MAPPED_RAM_CLEAR_EN
         state_q     <= CLEAR;
         clr_cnt_q   <= '0;
`endif
      end else begin
         rd_q        <= rd_d;
         out_valid_q <= out_valid_d;
         ready_q     <= ready_d;
`ifdef MAPPED_RAM_CLEAR_EN
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
`endif
      end
   end

   // Storage has no reset; only the CLEAR sweep or accepted writes change it.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int unsigned k = 0; k < NB_W; k++) begin
            if (mem_be[k]) begin
               mem_q[mem_idx][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
         end
      end
   end

   assign ready     = ready_q;
   assign out_valid = out_valid_q;
   assign out       = out_valid_q ? rd_q : 'z;

endmodule

// File: tb/tb_mapped_ram.sv
// Scoreboard bench for mapped_ram (DEPTH_LOG2=4): random ops checked against an array model.
// Follows MAPPED_RAM_CLEAR_EN for the expected ready latency and post-reset contents.
module tb_mapped_ram;

   localparam logic [7:0] BASE = 8'h02;
`ifdef MAPPED_RAM_CLEAR_EN
   localparam int unsigned EXP_EDGES = 16;
`else
   localparam int unsigned EXP_EDGES = 1;
`endif

   logic        clock;
   logic        reset_n;
   logic [63:0] address;
   logic [63:0] in;
   logic        write;
   logic        read;
   logic [7:0]  byte_en;
   wire         ready;
   wire         out_valid;
   wire  [63:0] out;

   mapped_ram #(
      .DATA_W(64), .ADDR_W(64), .DEPTH_LOG2(4), .ID_W(8), .BASE_ID(8'h02)
   ) dut (
      .clock(clock), .reset_n(reset_n), .address(address), .in(in),
      .write(write), .read(read), .byte_en(byte_en), .ready(ready),
      .out_valid(out_valid), .out(out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      bit          valid;
      bit          dc;
      logic [63:0] data;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] mdl   [16];
   bit          known [16];
   int unsigned checks = 0;
   int unsigned errors = 0;

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Monitor: one expectation per issued cycle, compared on the following falling edge.
   always @(negedge clock) begin
      exp_t e;
      if (reset_n) begin
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.valid) begin
               chk(out_valid == 1'b1, "out_valid_high", 64'(out_valid), 64'd1);
               if (!e.dc) chk(out == e.data, "read_data", out, e.data);
            end else begin
               chk(out_valid == 1'b0, "out_valid_low", 64'(out_valid), 64'd0);
               chk($isunknown(out) || out == '0, "out_hiz", out, '0);
            end
         end else if (out_valid) begin
            chk(1'b0, "spurious_out_valid", 64'(out_valid), 64'd0);
         end
      end
   end

   task automatic op(input logic [7:0] sid, input int unsigned idx, input logic rd, input logic wr,
                     input logic [63:0] d, input logic [7:0] be);
      exp_t e;
      bit   acc;
      address = {sid, 20'($urandom), 32'($urandom), 4'(idx)};
      in      = d;
      read    = rd;
      write   = wr;
      byte_en = be;
      @(posedge clock);
      acc     = (sid == BASE) && (rd || wr);
      e.valid = acc && rd;
      e.dc    = !known[idx];
      e.data  = mdl[idx];
      if (acc && wr) begin
         for (int k = 0; k < 8; k++) if (be[k]) mdl[idx][8*k +: 8] = d[8*k +: 8];
         if (be == 8'hFF) known[idx] = 1'b1;
      end
      exp_q.push_back(e);
      #1;
   endtask

   task automatic idle();
      op(BASE, 0, 1'b0, 1'b0, 64'd0, 8'd0);
   endtask

   task automatic wait_ready(input string nm);
      int unsigned n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (!ready && n < 200);
      chk(n == EXP_EDGES, nm, 64'(n), 64'(EXP_EDGES));
   endtask

   task automatic model_after_reset();
`ifdef MAPPED_RAM_CLEAR_EN
      for (int i = 0; i < 16; i++) begin
         mdl[i]   = '0;
         known[i] = 1'b1;
      end
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         mdl[i]   = '0;
         known[i] = 1'b0;
      end
      reset_n = 1'b0;
      address = '0;
      in      = '0;
      write   = 1'b0;
      read    = 1'b0;
      byte_en = '0;
      repeat (3) @(negedge clock);
      chk(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'd0);
      chk($isunknown(out) || out == '0, "reset_out_hiz", out, '0);
      chk(ready == 1'b0, "reset_ready", 64'(ready), 64'd0);
      reset_n = 1'b1;
      wait_ready("ready_latency");
      model_after_reset();

`ifdef MAPPED_RAM_CLEAR_EN
      for (int i = 0; i < 16; i++) op(BASE, i, 1'b1, 1'b0, 64'd0, 8'd0);
`endif
      for (int i = 0; i < 16; i++) op(BASE, i, 1'b0, 1'b1, {$urandom, $urandom}, 8'hFF);

      op(BASE, 5, 1'b0, 1'b1, 64'h1122334455667788, 8'hFF);
      op(BASE, 5, 1'b1, 1'b0, 64'd0, 8'd0);
      op(BASE, 5, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
      op(BASE, 5, 1'b1, 1'b0, 64'd0, 8'd0);
      op(8'h03, 5, 1'b1, 1'b1, 64'hDEADBEEFDEADBEEF, 8'hFF);
      op(BASE, 5, 1'b1, 1'b0, 64'd0, 8'd0);
      op(BASE, 5, 1'b1, 1'b1, 64'hA5, 8'hFF);
      op(BASE, 5, 1'b1, 1'b0, 64'd0, 8'd0);
      idle();
      op(BASE, 1, 1'b1, 1'b0, 64'd0, 8'd0);
      op(BASE, 2, 1'b1, 1'b0, 64'd0, 8'd0);
      op(BASE, 3, 1'b1, 1'b0, 64'd0, 8'd0);
      idle();

      for (int n = 0; n < 400; n++) begin
         logic [7:0] sid;
         sid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : BASE;
         op(sid, $urandom_range(0, 15), 1'($urandom), 1'($urandom), {$urandom, $urandom}, 8'($urandom));
      end
      idle();

      // Pending read killed by reset, then a second reset lands mid-sweep.
      address = {BASE, 52'd0, 4'd3};
      read    = 1'b1;
      @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk(out_valid == 1'b0, "abort_read_valid", 64'(out_valid), 64'd0);
      chk(ready == 1'b0, "abort_ready", 64'(ready), 64'd0);
      read = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (7) @(posedge clock);
      #1;
      chk(ready == (EXP_EDGES <= 7), "ready_mid_sweep", 64'(ready), 64'(EXP_EDGES <= 7));
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      wait_ready("ready_after_abort");
      model_after_reset();

      for (int i = 0; i < 16; i++) op(BASE, i, 1'b1, 1'b0, 64'd0, 8'd0);
      repeat (2) idle();
      read  = 1'b0;
      write = 1'b0;
      @(negedge clock);
      #1;
      chk(exp_q.size() == 0, "scoreboard_drain", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mapped_ram.md
MAPPED_RAM -- requirements
Module: mapped_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the data word width (a multiple of 8).
REQ-002 The block SHALL have parameter ADDR_W, default 64, giving the bus address width.
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 8, giving 2^DEPTH_LOG2 words.
REQ-004 The block SHALL have parameter ID_W, default 8, giving the width of the select field.
REQ-005 The block SHALL have parameter BASE_ID, default 8'b00000010, giving the select value that maps this instance.
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-007 Port clock, input, 1 bit: rising-edge clock.
REQ-008 Port reset_n, input, 1 bit: asynchronous reset, active low.
REQ-009 Port address, input, ADDR_W bits: select field is address[ADDR_W-1 -: ID_W]; word index is address[DEPTH_LOG2-1:0].
REQ-010 Port in, input, DATA_W bits: write data.
REQ-011 Port write, input, 1 bit: write request.
REQ-012 Port read, input, 1 bit: read request.
REQ-013 Port byte_en, input, DATA_W/8 bits: per-byte write enable; bit k covers in[8k+7:8k].
REQ-014 Port ready, output, 1 bit: high when requests are accepted.
REQ-015 Port out_valid, output, 1 bit: read data present on out.
REQ-016 Port out, output, DATA_W bits: read data; high-impedance whenever out_valid is 0.

Function
REQ-017 The block SHALL treat the instance as selected when the select field equals BASE_ID.
REQ-018 A request SHALL be accepted on a rising edge only when it is selected, ready=1, and read or write is 1.
REQ-019 An accepted write SHALL update only the byte lanes with byte_en=1 at that edge; lanes with byte_en=0 keep their value.
REQ-020 An accepted read SHALL drive out with the stored word and set out_valid=1 for exactly the cycle after acceptance (1-cycle latency).
REQ-021 An accepted read and write to the same index in the same cycle SHALL return the pre-write word (read-before-write); the write still takes effect.
REQ-022 Back-to-back accepted reads SHALL keep out_valid=1 continuously and return one word per cycle.
REQ-023 Unselected requests, and any request while ready=0, SHALL be ignored: no memory change and out_valid=0 the next cycle.
REQ-024 The block SHALL implement states CLEAR and RUN; ready=1 only in RUN.
REQ-025 In CLEAR the block SHALL write all-zero words to index 0, 1, ..., 2^DEPTH_LOG2-1, one word per cycle, then enter RUN on the next cycle.
REQ-026 The clear counter SHALL be DEPTH_LOG2+1 bits; the transition to RUN SHALL occur when it reaches 2^DEPTH_LOG2, with no wrap to index 0.

Reset
REQ-027 While reset_n=0, the block SHALL force out_valid=0, the read register to 0, and the clear counter to 0, with out high-impedance.
REQ-028 On reset release the block SHALL enter CLEAR when the clear feature is compiled in, and RUN otherwise.
REQ-029 Assertion of reset_n during CLEAR or RUN SHALL abort the operation; the next release SHALL restart the clear from index 0; a pending read SHALL produce no out_valid.
REQ-030 Reset SHALL NOT modify memory contents except through CLEAR.

Configuration
REQ-031 Macro MAPPED_RAM_CLEAR_EN defined: after reset the CLEAR sweep runs, ready=0 for 2^DEPTH_LOG2 cycles, and all words then read 0.
REQ-032 Macro MAPPED_RAM_CLEAR_EN undefined: the CLEAR state and counter are absent, ready=1 from the first cycle after reset release, and memory contents are undefined until written.

Verification
REQ-033 Write 64'h1122334455667788 with byte_en=8'hFF to index 5 (BASE_ID 2); read index 5 -> out_valid=1 one cycle later with out=64'h1122334455667788.
REQ-034 Then write 64'hFFFFFFFFFFFFFFFF with byte_en=8'h0F to index 5; read -> out=64'h11223344FFFFFFFF.
REQ-035 Read with select field 8'h03 -> out stays high-impedance, out_valid=0, and memory is unchanged.
REQ-036 Simultaneous read and write of 64'hA5 to index 5 (byte_en=8'hFF) -> out=64'h11223344FFFFFFFF; a following read returns 64'hA5.
REQ-037 With the macro defined and DEPTH_LOG2=4: ready=0 for 16 cycles after release; reassert reset at cycle 7 -> sweep restarts; afterwards every index reads 0.
REQ-038 Back-to-back reads of indices 1, 2, 3 -> out_valid held high for 3 consecutive cycles with data in request order.
